// File: rtl/aud_in_samp_wr.sv
// aud_in_samp_wr: writes a PCM sample stream into a sample-buffer ring of
// fixed-length frames, one 16-bit half per write.
// Ports: clk, rst_n (async, active-low); cfg_en capture enable;
// s_vld/s_rdy/s_data sample input; sample_buf_* core-side write port;
// frm_done/frm_idx completion pulse; frm_ack/frm_used held-frame count;
// ovf/ovf_clr sticky overflow.
// Macro AUD_IN_SAMP_WR_DROP_EN: drop samples while the ring is full
// (sets ovf). When undefined, the input stalls while full and ovf is 0.
module aud_in_samp_wr #(
    parameter int W = 16,
    parameter int S_BUF_AW = 10,
    parameter int FRAME_LEN = 256,
    localparam int NFRM = (2 ** (S_BUF_AW + 1)) / FRAME_LEN,
    localparam int FIDX_W = (NFRM > 1) ? $clog2(NFRM) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_en,
    input  logic                s_vld,
    output logic                s_rdy,
    input  logic [W-1:0]        s_data,
    input  logic                frm_ack,
    output logic [S_BUF_AW-1:0] sample_buf_addr,
    output logic                sample_buf_en,
    output logic                sample_buf_we,
    output logic [1:0]          sample_buf_wbe,
    output logic [2*W-1:0]      sample_buf_wdata,
    output logic                frm_done,
    output logic [FIDX_W-1:0]   frm_idx,
    output logic [FIDX_W:0]     frm_used,
    output logic                ovf,
    input  logic                ovf_clr
);

    localparam int LG = $clog2(FRAME_LEN);
    localparam logic [FIDX_W:0] NFRM_U = (FIDX_W + 1)'(NFRM);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t              state;
    logic [S_BUF_AW:0]   wp;
    logic                done_p;
    logic                acc;
    logic                wr;
    logic                inc;
    logic                dec;
    logic [FIDX_W:0]     used_nx;

    assign acc = (state == RUN) & s_vld & s_rdy;

`ifdef AUD_IN_SAMP_WR_DROP_EN
    logic full;
    assign full = (frm_used == NFRM_U);
    // a sample taken while full is swallowed: no write, pointer holds
    assign wr = acc & ~full;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign wr = acc;
    assign ovf = 1'b0;
`endif

    // last sample of a frame: low pointer bits all ones
    assign inc = wr & (&wp[LG-1:0]);
    assign dec = (state == RUN) & frm_ack & (frm_used != '0);

    always_comb begin
        used_nx = frm_used;
        if (inc & ~dec)
            used_nx = frm_used + 1'b1;
        else if (dec & ~inc)
            used_nx = frm_used - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            wp               <= '0;
            done_p           <= 1'b0;
            s_rdy            <= 1'b0;
            sample_buf_addr  <= '0;
            sample_buf_en    <= 1'b0;
            sample_buf_we    <= 1'b0;
            sample_buf_wbe   <= '0;
            sample_buf_wdata <= '0;
            frm_done         <= 1'b0;
            frm_idx          <= '0;
            frm_used         <= '0;
        end else begin
            sample_buf_en <= wr;
            sample_buf_we <= wr;
            if (wr) begin
                sample_buf_addr  <= wp[S_BUF_AW:1];
                sample_buf_wbe   <= wp[0] ? 2'b10 : 2'b01;
                sample_buf_wdata <= {s_data, s_data};
            end
            // completion is staged one cycle so it lands after its write
            done_p   <= inc;
            frm_done <= done_p;
            if (inc)
                frm_idx <= FIDX_W'(wp >> LG);

            unique case (state)
                IDLE: begin
                    wp       <= '0;
                    frm_used <= '0;
                    s_rdy    <= cfg_en;
                    if (cfg_en)
                        state <= RUN;
                end
                RUN: begin
                    if (wr)
                        wp <= wp + 1'b1;
                    frm_used <= used_nx;
                    if (!cfg_en) begin
                        state <= DRAIN;
                        s_rdy <= 1'b0;
                    end else begin
`ifdef AUD_IN_SAMP_WR_DROP_EN
                        s_rdy <= 1'b1;
`else
                        s_rdy <= (used_nx != NFRM_U);
`endif
                    end
                end
                DRAIN: begin
                    // last write is on the bus now, done_p drains
                    // through frm_done on this edge
                    wp       <= '0;
                    frm_used <= '0;
                    s_rdy    <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    s_rdy <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef AUD_IN_SAMP_WR_DROP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf <= 1'b0;
        else if (acc & full)
            ovf <= 1'b1;
        else if (ovf_clr)
            ovf <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_aud_in_samp_wr.sv
// tb_aud_in_samp_wr: directed bench for aud_in_samp_wr
// (W=16, S_BUF_AW=10, FRAME_LEN=256: 2048 samples, 8 frames).
module tb_aud_in_samp_wr;

    logic        clk;
    logic        rst_n;
    logic        cfg_en;
    logic        s_vld;
    logic        s_rdy;
    logic [15:0] s_data;
    logic        frm_ack;
    logic [9:0]  sample_buf_addr;
    logic        sample_buf_en;
    logic        sample_buf_we;
    logic [1:0]  sample_buf_wbe;
    logic [31:0] sample_buf_wdata;
    logic        frm_done;
    logic [2:0]  frm_idx;
    logic [3:0]  frm_used;
    logic        ovf;
    logic        ovf_clr;

    int total = 0;
    int bad = 0;

    int cyc = 0;
    int acc_cnt = 0;
    int last_acc_cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic [2:0] done_idx = '0;
    logic [3:0] done_used = '0;
    int viol = 0;
    logic [9:0]  wq_addr[$];
    logic [1:0]  wq_wbe[$];
    logic [31:0] wq_data[$];
    int          wq_cyc[$];

    aud_in_samp_wr dut (
        .clk(clk),
        .rst_n(rst_n),
        .cfg_en(cfg_en),
        .s_vld(s_vld),
        .s_rdy(s_rdy),
        .s_data(s_data),
        .frm_ack(frm_ack),
        .sample_buf_addr(sample_buf_addr),
        .sample_buf_en(sample_buf_en),
        .sample_buf_we(sample_buf_we),
        .sample_buf_wbe(sample_buf_wbe),
        .sample_buf_wdata(sample_buf_wdata),
        .frm_done(frm_done),
        .frm_idx(frm_idx),
        .frm_used(frm_used),
        .ovf(ovf),
        .ovf_clr(ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // bus observer, sampled mid-cycle
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst_n) begin
            if (s_vld && s_rdy) begin
                acc_cnt = acc_cnt + 1;
                last_acc_cyc = cyc;
            end
            if (sample_buf_we && !sample_buf_en)
                viol = viol + 1;
            if (sample_buf_en && !sample_buf_we)
                viol = viol + 1;
            if (sample_buf_en) begin
                if (sample_buf_wbe != 2'b01 && sample_buf_wbe != 2'b10)
                    viol = viol + 1;
                if (sample_buf_wdata[31:16] != sample_buf_wdata[15:0])
                    viol = viol + 1;
                wq_addr.push_back(sample_buf_addr);
                wq_wbe.push_back(sample_buf_wbe);
                wq_data.push_back(sample_buf_wdata);
                wq_cyc.push_back(cyc);
            end
            if (frm_done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
                done_idx = frm_idx;
                done_used = frm_used;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cfg_en = 1'b0;
        s_vld = 1'b0;
        s_data = '0;
        frm_ack = 1'b0;
        ovf_clr = 1'b0;
        repeat (3) step();
    endtask

    task automatic release_enable();
        rst_n = 1'b1;
        step();
        cfg_en = 1'b1;
        step();
    endtask

    // holds s_vld until n more accepts; s_vld is left high
    task automatic stream(input int n, input int budget,
                          input logic [15:0] base);
        int t0;
        int k;
        t0 = acc_cnt;
        k = 0;
        s_vld = 1'b1;
        while ((acc_cnt - t0) < n && k < budget) begin
            s_data = base + 16'(acc_cnt - t0);
            step();
            k++;
        end
        total++;
        if ((acc_cnt - t0) != n) begin
            bad++;
            $display("FAIL stream_budget accepted=%0d want=%0d",
                     acc_cnt - t0, n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({s_rdy, sample_buf_en, sample_buf_we, sample_buf_wbe}
            !== 5'b0) begin
            bad++;
            $display("FAIL rst_ctl got=%b want=0",
                     {s_rdy, sample_buf_en, sample_buf_we, sample_buf_wbe});
        end
        total++;
        if (sample_buf_addr !== 10'd0 || sample_buf_wdata !== 32'd0) begin
            bad++;
            $display("FAIL rst_bus addr=%h data=%h want=0",
                     sample_buf_addr, sample_buf_wdata);
        end
        total++;
        if ({frm_done, frm_idx, frm_used, ovf} !== 9'd0) begin
            bad++;
            $display("FAIL rst_frm got=%b want=0",
                     {frm_done, frm_idx, frm_used, ovf});
        end
    endtask

    task automatic test_single_write();
        int w0;
        release_enable();
        total++;
        if (s_rdy !== 1'b1) begin
            bad++;
            $display("FAIL run_rdy got=%b want=1", s_rdy);
        end
        w0 = wq_addr.size();
        s_vld = 1'b1;
        s_data = 16'h1111;
        step();
        s_data = 16'h2222;
        step();
        s_vld = 1'b0;
        repeat (3) step();
        total++;
        if (wq_addr.size() - w0 != 2) begin
            bad++;
            $display("FAIL sw_count got=%0d want=2", wq_addr.size() - w0);
        end else begin
            total++;
            if (wq_addr[w0] !== 10'd0 || wq_wbe[w0] !== 2'b01 ||
                wq_data[w0] !== 32'h11111111) begin
                bad++;
                $display("FAIL sw_first addr=%h wbe=%b data=%h want 0/01/11111111",
                         wq_addr[w0], wq_wbe[w0], wq_data[w0]);
            end
            total++;
            if (wq_addr[w0+1] !== 10'd0 || wq_wbe[w0+1] !== 2'b10 ||
                wq_data[w0+1] !== 32'h22222222) begin
                bad++;
                $display("FAIL sw_second addr=%h wbe=%b data=%h want 0/10/22222222",
                         wq_addr[w0+1], wq_wbe[w0+1], wq_data[w0+1]);
            end
            total++;
            if (wq_cyc[w0+1] - wq_cyc[w0] != 1) begin
                bad++;
                $display("FAIL sw_consec gap=%0d want=1",
                         wq_cyc[w0+1] - wq_cyc[w0]);
            end
        end
    endtask

    task automatic test_frame_done();
        int w0;
        int d0;
        int wl;
        do_reset();
        release_enable();
        w0 = wq_addr.size();
        d0 = done_cnt;
        stream(256, 300, 16'h0000);
        s_vld = 1'b0;
        repeat (4) step();
        total++;
        if (wq_addr.size() - w0 != 256) begin
            bad++;
            $display("FAIL fd_writes got=%0d want=256", wq_addr.size() - w0);
        end else begin
            wl = wq_addr.size() - 1;
            total++;
            if (wq_cyc[wl] - wq_cyc[w0] != 255) begin
                bad++;
                $display("FAIL fd_b2b span=%0d want=255",
                         wq_cyc[wl] - wq_cyc[w0]);
            end
            total++;
            if (wq_addr[wl] !== 10'd127 || wq_wbe[wl] !== 2'b10 ||
                wq_data[wl] !== 32'h00ff00ff) begin
                bad++;
                $display("FAIL fd_last addr=%0d wbe=%b data=%h want 127/10/00ff00ff",
                         wq_addr[wl], wq_wbe[wl], wq_data[wl]);
            end
        end
        total++;
        if (done_cnt - d0 != 1) begin
            bad++;
            $display("FAIL fd_done_cnt got=%0d want=1", done_cnt - d0);
        end
        total++;
        if (done_cyc - last_acc_cyc != 2) begin
            bad++;
            $display("FAIL fd_latency got=%0d want=2", done_cyc - last_acc_cyc);
        end
        total++;
        if (done_idx !== 3'd0 || done_used !== 4'd1) begin
            bad++;
            $display("FAIL fd_idx_used idx=%0d used=%0d want 0/1",
                     done_idx, done_used);
        end
    endtask

`ifndef AUD_IN_SAMP_WR_DROP_EN
    task automatic test_stall_wrap();
        int a0;
        int w0;
        int d0;
        do_reset();
        release_enable();
        a0 = acc_cnt;
        d0 = done_cnt;
        stream(2048, 2300, 16'h0000);
        total++;
        if (s_rdy !== 1'b0 || frm_used !== 4'd8) begin
            bad++;
            $display("FAIL st_full rdy=%b used=%0d want 0/8", s_rdy, frm_used);
        end
        repeat (10) step();
        total++;
        if (acc_cnt - a0 != 2048 || s_rdy !== 1'b0) begin
            bad++;
            $display("FAIL st_hold acc=%0d rdy=%b want 2048/0",
                     acc_cnt - a0, s_rdy);
        end
        total++;
        if (done_cnt - d0 != 8 || done_idx !== 3'd7 || done_used !== 4'd8) begin
            bad++;
            $display("FAIL st_dones n=%0d idx=%0d used=%0d want 8/7/8",
                     done_cnt - d0, done_idx, done_used);
        end
        s_data = 16'ha5a5;
        w0 = wq_addr.size();
        frm_ack = 1'b1;
        step();
        frm_ack = 1'b0;
        total++;
        if (frm_used !== 4'd7 || s_rdy !== 1'b1) begin
            bad++;
            $display("FAIL st_ack used=%0d rdy=%b want 7/1", frm_used, s_rdy);
        end
        repeat (4) step();
        s_vld = 1'b0;
        repeat (3) step();
        total++;
        if (wq_addr.size() - w0 != 4) begin
            bad++;
            $display("FAIL st_resume_cnt got=%0d want=4", wq_addr.size() - w0);
        end else begin
            total++;
            if (wq_addr[w0] !== 10'd0 || wq_wbe[w0] !== 2'b01 ||
                wq_data[w0] !== 32'ha5a5a5a5) begin
                bad++;
                $display("FAIL st_wrap addr=%0d wbe=%b data=%h want 0/01/a5a5a5a5",
                         wq_addr[w0], wq_wbe[w0], wq_data[w0]);
            end
        end
        total++;
        if (frm_used !== 4'd7 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL st_after used=%0d ovf=%b want 7/0", frm_used, ovf);
        end
    endtask
`else
    task automatic test_drop();
        int a0;
        int w0;
        do_reset();
        release_enable();
        stream(2048, 2300, 16'h0000);
        s_vld = 1'b0;
        repeat (3) step();
        w0 = wq_addr.size();
        a0 = acc_cnt;
        total++;
        if (s_rdy !== 1'b1 || frm_used !== 4'd8 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL dr_full rdy=%b used=%0d ovf=%b want 1/8/0",
                     s_rdy, frm_used, ovf);
        end
        s_vld = 1'b1;
        s_data = 16'h5555;
        repeat (5) step();
        s_vld = 1'b0;
        repeat (2) step();
        total++;
        if (acc_cnt - a0 != 5 || wq_addr.size() != w0) begin
            bad++;
            $display("FAIL dr_nowrite acc=%0d writes=%0d want 5/0",
                     acc_cnt - a0, wq_addr.size() - w0);
        end
        total++;
        if (ovf !== 1'b1) begin
            bad++;
            $display("FAIL dr_ovf got=%b want=1", ovf);
        end
        ovf_clr = 1'b1;
        s_vld = 1'b1;
        step();
        s_vld = 1'b0;
        total++;
        if (ovf !== 1'b1) begin
            bad++;
            $display("FAIL dr_set_wins got=%b want=1", ovf);
        end
        step();
        ovf_clr = 1'b0;
        total++;
        if (ovf !== 1'b0) begin
            bad++;
            $display("FAIL dr_clr got=%b want=0", ovf);
        end
        frm_ack = 1'b1;
        step();
        frm_ack = 1'b0;
        w0 = wq_addr.size();
        s_vld = 1'b1;
        s_data = 16'hbeef;
        step();
        s_vld = 1'b0;
        repeat (3) step();
        total++;
        if (wq_addr.size() - w0 != 1) begin
            bad++;
            $display("FAIL dr_resume_cnt got=%0d want=1", wq_addr.size() - w0);
        end else begin
            total++;
            if (wq_addr[w0] !== 10'd0 || wq_wbe[w0] !== 2'b01 ||
                wq_data[w0] !== 32'hbeefbeef) begin
                bad++;
                $display("FAIL dr_resume addr=%0d wbe=%b data=%h want 0/01/beefbeef",
                         wq_addr[w0], wq_wbe[w0], wq_data[w0]);
            end
        end
    endtask
`endif

    task automatic test_simultaneous();
        logic [3:0] want;
        do_reset();
        release_enable();
        stream(768, 900, 16'h0100);
        stream(255, 300, 16'h0400);
        s_data = 16'h04ff;
        frm_ack = 1'b1;
        step();
        frm_ack = 1'b0;
        s_vld = 1'b0;
        total++;
        if (frm_used !== 4'd3) begin
            bad++;
            $display("FAIL sim_ack_done got=%0d want=3", frm_used);
        end
        repeat (2) step();
        total++;
        if (done_idx !== 3'd3) begin
            bad++;
            $display("FAIL sim_idx got=%0d want=3", done_idx);
        end
        want = 4'd3;
        frm_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (want != 4'd0)
                want = want - 4'd1;
            total++;
            if (frm_used !== want) begin
                bad++;
                $display("FAIL sim_ack_%0d got=%0d want=%0d", i, frm_used, want);
            end
        end
        frm_ack = 1'b0;
    endtask

    task automatic test_disable();
        int w0;
        int d0;
        do_reset();
        release_enable();
        w0 = wq_addr.size();
        d0 = done_cnt;
        stream(99, 150, 16'h0200);
        s_data = 16'h0263;
        cfg_en = 1'b0;
        step();
        s_vld = 1'b0;
        total++;
        if (s_rdy !== 1'b0) begin
            bad++;
            $display("FAIL dis_rdy got=%b want=0", s_rdy);
        end
        total++;
        if (sample_buf_en !== 1'b1 || sample_buf_addr !== 10'd49 ||
            sample_buf_wbe !== 2'b10 || sample_buf_wdata !== 32'h02630263) begin
            bad++;
            $display("FAIL dis_lastwr en=%b addr=%0d wbe=%b data=%h want 1/49/10/02630263",
                     sample_buf_en, sample_buf_addr, sample_buf_wbe,
                     sample_buf_wdata);
        end
        repeat (3) step();
        total++;
        if (wq_addr.size() - w0 != 100 || done_cnt != d0) begin
            bad++;
            $display("FAIL dis_tail writes=%0d dones=%0d want 100/0",
                     wq_addr.size() - w0, done_cnt - d0);
        end
        total++;
        if (frm_used !== 4'd0 || s_rdy !== 1'b0) begin
            bad++;
            $display("FAIL dis_idle used=%0d rdy=%b want 0/0", frm_used, s_rdy);
        end
        cfg_en = 1'b1;
        step();
        w0 = wq_addr.size();
        s_vld = 1'b1;
        s_data = 16'h0777;
        step();
        s_vld = 1'b0;
        repeat (3) step();
        total++;
        if (wq_addr.size() - w0 != 1) begin
            bad++;
            $display("FAIL dis_reen_cnt got=%0d want=1", wq_addr.size() - w0);
        end else begin
            total++;
            if (wq_addr[w0] !== 10'd0 || wq_wbe[w0] !== 2'b01) begin
                bad++;
                $display("FAIL dis_reen addr=%0d wbe=%b want 0/01",
                         wq_addr[w0], wq_wbe[w0]);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        release_enable();
        stream(276, 350, 16'h3000);
        s_vld = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if ({s_rdy, sample_buf_en, sample_buf_we, sample_buf_wbe}
            !== 5'b0) begin
            bad++;
            $display("FAIL ar_ctl got=%b want=0",
                     {s_rdy, sample_buf_en, sample_buf_we, sample_buf_wbe});
        end
        total++;
        if (sample_buf_addr !== 10'd0 || sample_buf_wdata !== 32'd0) begin
            bad++;
            $display("FAIL ar_bus addr=%h data=%h want=0",
                     sample_buf_addr, sample_buf_wdata);
        end
        total++;
        if ({frm_done, frm_idx, frm_used, ovf} !== 9'd0) begin
            bad++;
            $display("FAIL ar_frm got=%b want=0",
                     {frm_done, frm_idx, frm_used, ovf});
        end
        cfg_en = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_strobes();
        total++;
        if (viol != 0) begin
            bad++;
            $display("FAIL strobe_rules got=%0d want=0", viol);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cfg_en = 1'b0;
        s_vld = 1'b0;
        s_data = '0;
        frm_ack = 1'b0;
        ovf_clr = 1'b0;
        test_reset();
        test_single_write();
        test_frame_done();
`ifndef AUD_IN_SAMP_WR_DROP_EN
        test_stall_wrap();
`else
        test_drop();
`endif
        test_simultaneous();
        test_disable();
        test_async_reset();
        test_strobes();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aud_in_samp_wr.md
# aud_in_samp_wr

Audio input front-end writer that sits upstream of the DSP bus mux. It accepts a PCM sample stream over a valid/ready handshake and writes each sample into the sample buffer's core-side port, one 16-bit half per write. The buffer is managed as a ring of fixed-length frames. The block signals each completed frame to the DSP core and tracks how many frames the core still holds, so the ring never overwrites unconsumed data.

## Interface
Parameters:
- `W`, 16, sample width; the buffer word is `2*W`.
- `S_BUF_AW`, 10, sample-buffer word-address width. Capacity is `2^(S_BUF_AW+1)` samples.
- `FRAME_LEN`, 256, samples per frame. Must be a power of 2, at least 2, and at most the capacity.
- Derived: `NFRM = 2^(S_BUF_AW+1)/FRAME_LEN`, and `FIDX_W = max(1, clog2(NFRM))`.

Ports (clock and reset first):
- `clk`  in  1  — single clock for the whole block.
- `rst_n`  in  1  — reset; asynchronous, active-low.
- `cfg_en`  in  1  — capture enable (level).
- `s_vld`  in  1  — input sample valid.
- `s_rdy`  out  1  — input sample ready.
- `s_data`  in  W  — PCM sample, stored unmodified.
- `frm_ack`  in  1  — one-cycle pulse; the core releases its oldest held frame.
- `sample_buf_addr`  out  S_BUF_AW  — buffer word address.
- `sample_buf_en`  out  1  — buffer access strobe.
- `sample_buf_we`  out  1  — buffer write enable.
- `sample_buf_wbe`  out  2  — half-word enable, one-hot.
- `sample_buf_wdata`  out  2*W  — write data, `{s_data, s_data}`.
- `frm_done`  out  1  — one-cycle pulse; a frame has been completely written.
- `frm_idx`  out  FIDX_W  — index of the frame just completed (mod NFRM).
- `frm_used`  out  FIDX_W+1  — frames written but not yet acked.
- `ovf`  out  1  — sticky overflow flag.
- `ovf_clr`  in  1  — clears `ovf`.

## Operation
- State machine with states IDLE, RUN and DRAIN. Reset state is IDLE.
- **IDLE**
  - `s_rdy` = 0, the sample pointer `wp` (S_BUF_AW+1 bits) = 0, and `frm_used` = 0.
  - If `cfg_en` = 1, move to RUN.
- **RUN**
  - An accept is `s_vld & s_rdy`. Each accept registers a write for the next cycle:
    - `addr = wp[S_BUF_AW:1]`
    - `wbe = wp[0] ? 2'b10 : 2'b01`
    - `en = we = 1`
  - Then `wp` increments and wraps from `2^(S_BUF_AW+1)-1` to 0.
  - Full means `frm_used == NFRM`.
  - When the accepted sample has `wp[log2(FRAME_LEN)-1:0] == FRAME_LEN-1`, `frm_used` increments in that same edge.
  - `frm_ack` with `frm_used > 0` decrements `frm_used`. `frm_ack` with `frm_used == 0` is ignored.
  - If a completion and an ack happen in the same cycle, `frm_used` is unchanged.
  - If `cfg_en` = 0, move to DRAIN and deassert `s_rdy` immediately.
- **DRAIN**
  - Waits until any in-flight write and pending `frm_done` have been issued (at most 2 cycles), then moves to IDLE.
  - A partially filled frame is discarded, with no `frm_done`.
- `ovf_clr` clears `ovf`. If a set and a clear happen in the same cycle, the set wins.
- `sample_buf_we` is never asserted without `sample_buf_en`. No read accesses are ever issued.

## Timing
- All outputs are registered. Reset values:
  - `s_rdy`=0, `sample_buf_en`=0, `sample_buf_we`=0, `sample_buf_wbe`=0.
  - `sample_buf_addr`=0, `sample_buf_wdata`=0.
  - `frm_done`=0, `frm_idx`=0, `frm_used`=0, `ovf`=0.
- Accept in cycle N produces the buffer write strobe in cycle N+1. For the last sample of a frame, `frm_done` is high in cycle N+2, and `frm_idx` is valid with it.
- Throughput is one sample per cycle.
- `frm_used` (and therefore full) updates at the edge ending the accept cycle, so `s_rdy` reflects full from cycle N+1.
- `frm_ack` takes effect at the edge of the cycle it is high. `s_rdy` can reassert in the next cycle.
- Asserting `rst_n` mid-frame clears everything immediately. Any strobe in flight is lost.

## Configuration
- Macro `AUD_IN_SAMP_WR_DROP_EN`.
- **Defined (drop mode)**
  - In RUN, `s_rdy` = 1 even when full.
  - Samples accepted while full are discarded: no write, `wp` holds, and `ovf` is set.
  - Capture resumes at the same frame boundary after an ack.
- **Undefined (stall mode)**
  - In RUN, `s_rdy = !full`.
  - No sample is ever dropped. `ovf` is tied to 0 and `ovf_clr` is ignored.

## Test plan
1. **Reset and single write.** Reset, `cfg_en`=1, send samples 0x1111 then 0x2222.
   - Writes: addr 0 / wbe 01 / wdata 0x11111111, then addr 0 / wbe 10 / wdata 0x22222222, in consecutive cycles.
2. **Frame completion.** Stream 256 samples back-to-back.
   - `frm_done` pulses once, 2 cycles after the 256th accept, with `frm_idx`=0 and `frm_used`=1.
   - The last write is at addr 127, wbe 10.
3. **Fill, stall and ring wrap (stall build).** Stream 2048+4 samples with no acks.
   - `s_rdy` drops after accept 2048, with `frm_used`=8.
   - One `frm_ack` brings `frm_used` to 7; `s_rdy` returns the next cycle, and the next write goes to addr 0, wbe 01.
4. **Drop mode (`AUD_IN_SAMP_WR_DROP_EN`).** Fill to full, then send 5 samples.
   - No writes occur and `ovf`=1.
   - `ovf_clr` together with a new drop leaves `ovf`=1; `ovf_clr` alone clears it.
   - After an ack, the next write is at addr 0.
5. **Simultaneous events.** Assert `frm_ack` in the same cycle as a frame's last accept, with `frm_used`=3: `frm_used` stays 3.
   - `frm_ack` with `frm_used`=0 leaves it at 0.
6. **Disable and async reset mid-frame.**
   - Drop `cfg_en` after 100 samples: `s_rdy`=0 next cycle, the last write is still issued, no `frm_done`, and the block is in IDLE within 2 cycles. Re-enabling starts again at addr 0.
   - Assert `rst_n` low mid-stream: all outputs go to their reset values asynchronously.
